// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared types and register map for the UART transmit controller
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_BUSY  = 2'd3
    } state_t;

    // Register selects, compared against addr_i[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_COUNT = 8;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_OVF_CLR = 1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head and occupancy count
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - bus-mapped TX controller: FIFO, register decode and uart_tx sequencer
module uart_tx_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DW         = 32,
    parameter int DW_UART    = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cs,
    input  logic               we,
    input  logic [3:0]         addr_i,
    input  logic [DW-1:0]      wdata_i,
    output logic [DW-1:0]      rdata_o,
    output logic [DW_UART-1:0] data_o,
    output logic               byte_ready,
    output logic               t_byte,
    input  logic               done_uart,
    output logic               intr_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t             r_state;
    logic [DW_UART-1:0] r_hold;
    logic               r_byte_ready;
    logic               r_t_byte;
    logic               r_ovf;
    logic               r_irq_en;
    logic [DW-1:0]      r_rdata;

    logic [1:0]         w_sel;
    logic               w_push;
    logic               w_pop;
    logic               w_ctrl_wr;
    logic               w_ovf_set;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic [DW_UART-1:0] w_head;
    logic [DW-1:0]      w_status;
    logic [DW-1:0]      w_rd_mux;
    logic               w_unused_bits;

    assign w_sel     = addr_i[3:2];
    assign w_push    = cs & we & (w_sel == REG_TXDATA);
    assign w_ctrl_wr = cs & we & (w_sel == REG_CTRL);
    // The head leaves the FIFO on IDLE->LOAD and on BUSY->LOAD
    assign w_pop     = ~w_empty & ((r_state == ST_IDLE) | ((r_state == ST_BUSY) & done_uart));
    assign w_ovf_set = w_push & w_full & ~w_pop;
    assign w_unused_bits = ^{addr_i[1:0], wdata_i[DW-1:DW_UART]};

    sync_fifo #(
        .WIDTH (DW_UART),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (w_push),
        .pop   (w_pop),
        .din   (wdata_i[DW_UART-1:0]),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_comb begin
        w_status                   = '0;
        w_status[STAT_BUSY]        = (r_state != ST_IDLE);
        w_status[STAT_FULL]        = w_full;
        w_status[STAT_EMPTY]       = w_empty;
        w_status[STAT_OVF]         = r_ovf;
        w_status[STAT_COUNT +: CW] = w_count;
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            REG_STATUS: w_rd_mux = w_status;
            REG_CTRL:   w_rd_mux[CTRL_IRQ_EN] = r_irq_en;
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ST_IDLE;
            r_hold       <= '0;
            r_byte_ready <= 1'b0;
            r_t_byte     <= 1'b0;
        end else begin
            r_byte_ready <= 1'b0;
            r_t_byte     <= 1'b0;
            if (w_pop) begin
                r_hold <= w_head;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state      <= ST_LOAD;
                        r_byte_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_state  <= ST_START;
                    r_t_byte <= 1'b1;
                end
                ST_START: begin
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (done_uart) begin
                        if (!w_empty) begin
                            r_state      <= ST_LOAD;
                            r_byte_ready <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ovf    <= 1'b0;
            r_irq_en <= 1'b0;
            r_rdata  <= '0;
        end else begin
            // A dropped byte wins over a clear written in the same cycle
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ctrl_wr && wdata_i[CTRL_OVF_CLR]) begin
                r_ovf <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_irq_en <= wdata_i[CTRL_IRQ_EN];
            end
            if (cs && !we) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign rdata_o    = r_rdata;
    assign data_o     = r_hold;
    assign byte_ready = r_byte_ready;
    assign t_byte     = r_t_byte;
    assign intr_o     = r_irq_en & w_empty & (r_state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - randomized bench for uart_tx_ctrl against a queue-based reference
module tb_uart_tx_ctrl;

    localparam int DW  = 32;
    localparam int DWU = 8;
    localparam int D   = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs    = 1'b0;
    logic          we    = 1'b0;
    logic          done  = 1'b0;
    logic [3:0]    addr  = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic [DWU-1:0] data_o;
    logic          byte_ready;
    logic          t_byte;
    logic          intr;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .DW         (DW),
        .DW_UART    (DWU),
        .FIFO_DEPTH (D)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .cs         (cs),
        .we         (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .data_o     (data_o),
        .byte_ready (byte_ready),
        .t_byte     (t_byte),
        .done_uart  (done),
        .intr_o     (intr)
    );

    // Reference: a byte queue plus "cycles since the last pop" for the frame in flight
    logic [7:0]  mq[$];
    bit          m_active = 0;
    int          m_since  = 0;
    logic [7:0]  m_data   = '0;
    bit          m_ovf    = 0;
    bit          m_irq    = 0;
    logic [31:0] m_rdata  = '0;

    function automatic logic [31:0] m_status();
        int n;
        n = mq.size();
        return 32'(n * 256 + (m_ovf ? 8 : 0) + (n == 0 ? 4 : 0) + (n == D ? 2 : 0) + (m_active ? 1 : 0));
    endfunction

    function automatic bit m_br();
        return m_active && m_since == 1;
    endfunction

    function automatic bit m_tb();
        return m_active && m_since == 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_active = 0;
            m_since  = 0;
            m_data   = '0;
            m_ovf    = 0;
            m_irq    = 0;
            m_rdata  = '0;
        end else begin
            int n;
            bit waiting;
            bit pop;
            logic [31:0] st;
            n       = mq.size();
            waiting = m_active && m_since >= 3;
            pop     = (n > 0) && (!m_active || (waiting && done));
            st      = m_status();
            if (cs && !we)
                m_rdata = (addr[3:2] == 1) ? st : (addr[3:2] == 2) ? {31'b0, m_irq} : 32'd0;
            if (cs && we && addr[3:2] == 2) begin
                m_irq = wdata[0];
                if (wdata[1]) m_ovf = 0;
            end
            if (pop) m_data = mq.pop_front();
            if (cs && we && addr[3:2] == 0) begin
                if (n < D || pop) mq.push_back(wdata[7:0]);
                else m_ovf = 1;
            end
            if (pop) begin
                m_active = 1;
                m_since  = 1;
            end else if (waiting && done) begin
                m_active = 0;
            end else if (m_active && m_since < 3) begin
                m_since++;
            end
        end
    end

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("byte_ready", 32'(byte_ready), 32'(m_br()));
        chk("t_byte", 32'(t_byte), 32'(m_tb()));
        chk("data_o", 32'(data_o), 32'(m_data));
        chk("rdata_o", rdata, m_rdata);
        chk("intr_o", 32'(intr), 32'(m_irq && mq.size() == 0 && !m_active));
    endtask

    // uart_tx stand-in: done_uart follows t_byte after rsp_delay cycles
    int         rsp_cnt    = -1;
    int         rsp_delay  = 5;
    int         spur       = 0;
    bit         force_done = 0;
    logic [7:0] sent[$];

    task automatic tick(input bit c, input bit w, input logic [3:0] a, input logic [31:0] d);
        cs    = c;
        we    = w;
        addr  = a;
        wdata = d;
        done  = force_done || rsp_cnt == 0 || (spur > 0 && $urandom_range(spur - 1) == 0);
        force_done = 0;
        if (rsp_cnt >= 0) rsp_cnt--;
        @(posedge clk);
        @(negedge clk);
        compare();
        if (byte_ready) sent.push_back(data_o);
        if (m_tb()) rsp_cnt = rsp_delay;
    endtask

    task automatic idle();
        tick(0, 0, 4'h0, 32'h0);
    endtask

    task automatic push(input logic [7:0] b);
        tick(1, 1, 4'h0, {24'h0, b});
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        tick(1, 0, a, 32'h0);
        v = rdata;
    endtask

    task automatic wr_ctrl(input logic [31:0] v);
        tick(1, 1, 4'h8, v);
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while ((m_active || mq.size() != 0) && k < max) begin
            idle();
            k++;
        end
        chk("idle_reached", 32'(m_active || mq.size() != 0), 32'd0);
    endtask

    initial begin
        logic [31:0] v;

        repeat (3) @(negedge clk);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_t_byte", 32'(t_byte), 32'd0);
        chk("rst_data_o", 32'(data_o), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_intr", 32'(intr), 32'd0);
        rst_n = 1'b1;
        rd(4'h4, v);
        chk("status_reset", v, 32'h4);

        // Single byte: LOAD one cycle after the push edge, START the next
        rsp_delay = 100;
        push(8'h41);
        idle();
        chk("first_load", 32'(byte_ready), 32'd1);
        chk("first_data", 32'(data_o), 32'h41);
        idle();
        chk("first_start", 32'(t_byte), 32'd1);
        rd(4'h4, v);
        chk("status_busy", v, 32'h5);
        wait_idle(300);

        // Three bytes leave in order
        sent.delete();
        push(8'h10);
        push(8'h11);
        push(8'h12);
        wait_idle(1000);
        chk("seq_count", 32'(sent.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("seq_byte", (i < sent.size()) ? 32'(sent[i]) : 32'hFFFF, 32'(8'h10 + i));

        // Overflow while the frame is in flight
        rsp_delay = 10000;
        push(8'h20);
        repeat (4) idle();
        for (int i = 0; i < 10; i++) push(8'(8'h30 + i));
        rd(4'h4, v);
        chk("status_ovf", v, 32'h80B);
        wr_ctrl(32'h2);
        rd(4'h4, v);
        chk("status_ovf_clr", v, 32'h803);

        // Push into a full FIFO in the same cycle the head leaves
        rsp_delay = 3;
        force_done = 1;
        push(8'h55);
        chk("pushpop_load", 32'(byte_ready), 32'd1);
        rd(4'h4, v);
        chk("status_pushpop", v, 32'h803);

        // TX-empty interrupt
        wr_ctrl(32'h1);
        wait_idle(500);
        idle();
        chk("intr_high", 32'(intr), 32'd1);
        push(8'h66);
        chk("intr_drop", 32'(intr), 32'd0);
        wait_idle(200);
        force_done = 1;
        idle();
        chk("idle_done_ignored", 32'(byte_ready), 32'd0);
        rd(4'h4, v);
        chk("status_idle_done", v, 32'h4);

        // Reset during START with three bytes queued
        wr_ctrl(32'h0);
        rsp_delay = 10000;
        push(8'h70);
        repeat (4) idle();
        for (int i = 0; i < 4; i++) push(8'(8'h71 + i));
        force_done = 1;
        idle();
        idle();
        chk("pre_reset_start", 32'(t_byte), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_byte_ready", 32'(byte_ready), 32'd0);
        chk("midrst_t_byte", 32'(t_byte), 32'd0);
        chk("midrst_data_o", 32'(data_o), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_intr", 32'(intr), 32'd0);
        rsp_cnt = -1;
        idle();
        rst_n = 1'b1;
        rd(4'h4, v);
        chk("status_after_rst", v, 32'h4);

        // Randomized traffic with stray done_uart pulses
        spur = 16;
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = $urandom_range(9);
            rsp_delay = $urandom_range(12, 1);
            if (r < 3)       push(8'($urandom));
            else if (r == 3) tick(1, 0, 4'($urandom_range(15)), 32'h0);
            else if (r == 4) tick(1, 1, 4'($urandom_range(15)), $urandom);
            else             idle();
        end
        spur = 0;
        rsp_delay = 4;
        wait_idle(2000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Memory-mapped transmit controller that sits between the peripheral bus and `uart_tx`, replacing the direct `cs_uart`-to-`uart_tx` handshake. Store bytes written by the core are buffered in a small FIFO. A sequencer drains the FIFO into `uart_tx` one byte at a time using the `byte_ready`/`t_byte`/`done_uart` handshake. Status and control registers let software poll the FIFO level or take a TX-empty interrupt.

## Interface
- `DW`, 32, bus data width
- `DW_UART`, 8, UART byte width
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, ≥2
- `clk_i`  in  1  core clock
- `rst_i`  in  1  asynchronous, active-low reset
- `cs`  in  1  UART select from `peripherals_bus`; one access per cycle
- `we`  in  1  write strobe; qualified by `cs`
- `addr_i`  in  4  byte offset; only `[3:2]` decoded
- `wdata_i`  in  DW  store data
- `rdata_o`  out  DW  registered load data
- `data_o`  out  DW_UART  byte presented to `uart_tx.data_i`
- `byte_ready`  out  1  load pulse to `uart_tx.byte_ready_i`
- `t_byte`  out  1  start pulse to `uart_tx.t_byte_i`
- `done_uart`  in  1  one-cycle pulse from `uart_tx` at end of frame
- `intr_o`  out  1  TX-empty interrupt, level

## Operation
- Register map:
  - 0x0 TXDATA
    - Write: push `wdata_i[DW_UART-1:0]`.
    - Read: 0.
  - 0x4 STATUS, read-only:
    - `[0]` busy (state ≠ IDLE)
    - `[1]` full
    - `[2]` empty
    - `[3]` overflow, sticky
    - `[8+:$clog2(FIFO_DEPTH)+1]` count
  - 0x8 CTRL
    - `[0]` irq_en, R/W.
    - Writing `[1]=1` clears overflow. `[1]` reads 0.
  - 0xC: reads 0; writes ignored.
- Push rules:
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Overflow set takes priority over a same-cycle clear.
- FSM states IDLE, LOAD, START, BUSY:
  - IDLE → LOAD when FIFO is non-empty. The head is popped into the hold register on this transition.
  - LOAD: `byte_ready`=1 for exactly one cycle; `data_o` = hold register. → START.
  - START: `t_byte`=1 for exactly one cycle. → BUSY.
  - BUSY: wait for `done_uart`. On `done_uart`:
    - FIFO non-empty → LOAD, popping the head on the transition.
    - FIFO empty → IDLE.
  - `done_uart` is ignored in every state except BUSY.
- `data_o` holds its value until the next pop.
- `intr_o` = irq_en & empty & (state == IDLE).
- Count is `$clog2(FIFO_DEPTH)+1` bits. Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.

## Timing
- Reset values:
  - state IDLE; FIFO empty; count 0
  - overflow 0; irq_en 0
  - `rdata_o` 0, `data_o` 0, `byte_ready` 0, `t_byte` 0, `intr_o` 0
- Writes (register update and push) take effect at the clock edge where `cs & we`.
- Reads: `rdata_o` is valid one cycle after `cs & !we`, matching the delayed-select timing of `data_mem`. Otherwise `rdata_o` holds its last value.
- Push into an empty FIFO while IDLE, at edge N:
  - LOAD in cycle N+1
  - START in cycle N+2
  - BUSY from N+3
- `done_uart` at edge M with FIFO non-empty: LOAD in cycle M+1. Back-to-back frames have a two-cycle gap, LOAD and START.
- STATUS read in the same cycle as a push returns the pre-push values.
- `rst_i` asserted mid-frame:
  - Everything returns to reset values immediately; the FIFO contents are discarded.
  - `uart_tx` shares the reset, so no partial handshake persists.

## Structure
- `uart_ctrl_pkg`:
  - state enum: IDLE, LOAD, START, BUSY
  - register offset constants: TXDATA, STATUS, CTRL
  - STATUS and CTRL bit-index constants
- Sub-module `sync_fifo`, parameterized by width and depth:
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`.
  - Head is read combinationally.
- `uart_tx_ctrl` holds the FSM, register decode, hold register and interrupt logic.

## Test plan
- Reset, then push 0x41 at edge 0 → `byte_ready`=1 in cycle 1 with `data_o`=0x41; `t_byte`=1 in cycle 2; STATUS busy=1 until `done_uart`.
- Push 0x10, 0x11, 0x12 back-to-back; model `done_uart` 100 cycles after each `t_byte` → bytes leave in order; LOAD follows each `done_uart` by 1 cycle; IDLE after the third.
- Push 10 bytes while BUSY with DEPTH=8 → STATUS count=8, full=1, overflow=1; the last bytes are dropped. Write CTRL=0x2 → overflow=0.
- With full FIFO and `done_uart`-triggered pop in the same cycle as a push → push accepted; count stays 8; overflow stays 0.
- CTRL=0x1, drain FIFO → `intr_o` rises the cycle after BUSY→IDLE; a push drops it. Assert `done_uart` in IDLE → no state change.
- Assert `rst_i` low while in START with 3 bytes queued → all outputs 0, STATUS reads 0x4 (empty).
